// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_issue_stage_if                                            |
// | Purpose  : Bundles the upstream instruction handshake and the downstream |
// |            ALU issue handshake of alu_issue_stage.                       |
// | Ports    : upstream  in_valid/in_ready, opcode, funct3, funct7,          |
// |                      rs1_val, rs2_val, imm, pc, flush                    |
// |            downstream out_valid/out_ready, alu_op, ina, inb,             |
// |                      is_branch, br_inv, illegal                          |
// | Modports : master = instruction source / ALU sink (drives in_*, flush,   |
// |            out_ready); slave = the issue stage itself.                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface alu_issue_stage_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] ina;
  logic [DATA_W-1:0] inb;
  logic              is_branch;
  logic              br_inv;
  logic              illegal;

  modport master (
    output in_valid, opcode, funct3, funct7, rs1_val, rs2_val, imm, pc,
           flush, out_ready,
    input  in_ready, out_valid, alu_op, ina, inb, is_branch, br_inv, illegal
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7, rs1_val, rs2_val, imm, pc,
           flush, out_ready,
    output in_ready, out_valid, alu_op, ina, inb, is_branch, br_inv, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_issue_stage                                               |
// | Purpose  : RV32I decode-and-issue register in front of the ALU. Decodes  |
// |            opcode/funct3/funct7 into a 4-bit ALU op, selects operands    |
// |            from rs1/rs2/imm/pc, and holds the result in a one-entry      |
// |            valid/ready pipeline register with flush.                     |
// | Ports    : clk    - clock, rising edge                                   |
// |            rst_n  - asynchronous reset, active low                       |
// |            bus    - alu_issue_stage_if.slave (both handshakes)           |
// | Options  : ALU_ISSUE_ILLEGAL_EN - when defined, unsupported encodings    |
// |            issue as NOP (op 15, operands 0) with illegal = 1; otherwise  |
// |            they issue as ADD rs1+imm and illegal stays 0.                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module alu_issue_stage #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_issue_stage_if.slave    bus
);

  // ALU operation codes
  localparam logic [3:0] c_OP_AND  = 4'd0;
  localparam logic [3:0] c_OP_OR   = 4'd1;
  localparam logic [3:0] c_OP_ADD  = 4'd2;
  localparam logic [3:0] c_OP_XOR  = 4'd3;
  localparam logic [3:0] c_OP_SLL  = 4'd4;
  localparam logic [3:0] c_OP_SRL  = 4'd5;
  localparam logic [3:0] c_OP_SUB  = 4'd6;
  localparam logic [3:0] c_OP_SLTU = 4'd7;
  localparam logic [3:0] c_OP_SLT  = 4'd8;
  localparam logic [3:0] c_OP_SRA  = 4'd9;
  localparam logic [3:0] c_OP_NOP  = 4'd15;

  // RV32I major opcodes
  localparam logic [6:0] c_OPC_R      = 7'b0110011;
  localparam logic [6:0] c_OPC_I      = 7'b0010011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

  // Registered state
  logic              out_valid_q, out_valid_d;
  logic [3:0]        alu_op_q,    alu_op_d;
  logic [DATA_W-1:0] ina_q,       ina_d;
  logic [DATA_W-1:0] inb_q,       inb_d;
  logic              is_branch_q, is_branch_d;
  logic              br_inv_q,    br_inv_d;
  logic              illegal_q,   illegal_d;

  // Decode results
  logic [3:0]        w_dec_op;
  logic [DATA_W-1:0] w_dec_a;
  logic [DATA_W-1:0] w_dec_b;
  logic              w_dec_br;
  logic              w_dec_inv;
  logic              w_dec_ill;   // raw detection, before build option
  logic              w_alt;       // funct7[5]: SUB / SRA select
  logic [3:0]        w_arith_op;  // shared R/I funct3 translation
  logic              w_accept;

  // Only funct7[5] carries meaning for RV32I base ALU ops.
  logic              unused_funct7;
  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

  assign w_alt = bus.funct7[5];

  // funct3 translation common to R-type and I-type. SUB is qualified by
  // opcode later since ADDI never becomes a subtract.
  always_comb begin
    w_arith_op = c_OP_ADD;
    case (bus.funct3)
      3'b000:  w_arith_op = c_OP_ADD;
      3'b001:  w_arith_op = c_OP_SLL;
      3'b010:  w_arith_op = c_OP_SLT;
      3'b011:  w_arith_op = c_OP_SLTU;
      3'b100:  w_arith_op = c_OP_XOR;
      3'b101:  w_arith_op = w_alt ? c_OP_SRA : c_OP_SRL;
      3'b110:  w_arith_op = c_OP_OR;
      default: w_arith_op = c_OP_AND;
    endcase
  end

  always_comb begin
    w_dec_op  = c_OP_ADD;
    w_dec_a   = bus.rs1_val;
    w_dec_b   = bus.imm;
    w_dec_br  = 1'b0;
    w_dec_inv = 1'b0;
    w_dec_ill = 1'b0;
    case (bus.opcode)
      c_OPC_R: begin
        w_dec_op = (bus.funct3 == 3'b000 && w_alt) ? c_OP_SUB : w_arith_op;
        w_dec_b  = bus.rs2_val;
      end
      c_OPC_I: begin
        w_dec_op = w_arith_op;
      end
      c_OPC_LOAD, c_OPC_STORE, c_OPC_JALR: begin
        w_dec_op = c_OP_ADD;
      end
      c_OPC_LUI: begin
        w_dec_a = '0;
      end
      c_OPC_AUIPC: begin
        w_dec_a = bus.pc;
      end
      c_OPC_BRANCH: begin
        w_dec_b  = bus.rs2_val;
        w_dec_br = 1'b1;
        // funct3[0] selects the inverted sense (BNE/BGE/BGEU).
        w_dec_inv = bus.funct3[0];
        case (bus.funct3[2:1])
          2'b00:   w_dec_op = c_OP_SUB;
          2'b10:   w_dec_op = c_OP_SLT;
          2'b11:   w_dec_op = c_OP_SLTU;
          default: w_dec_ill = 1'b1;
        endcase
      end
      default: w_dec_ill = 1'b1;
    endcase

    // Illegal encodings never look like branches downstream.
    if (w_dec_ill) begin
      w_dec_br  = 1'b0;
      w_dec_inv = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      w_dec_op  = c_OP_NOP;
      w_dec_a   = '0;
      w_dec_b   = '0;
`else
      w_dec_op  = c_OP_ADD;
      w_dec_a   = bus.rs1_val;
      w_dec_b   = bus.imm;
`endif
    end
  end

  // A free slot or a consuming ALU frees the register; flush does not gate it.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    alu_op_d    = alu_op_q;
    ina_d       = ina_q;
    inb_d       = inb_q;
    is_branch_d = is_branch_q;
    br_inv_d    = br_inv_q;
    illegal_d   = illegal_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (w_accept) begin
      out_valid_d = 1'b1;
      alu_op_d    = w_dec_op;
      ina_d       = w_dec_a;
      inb_d       = w_dec_b;
      is_branch_d = w_dec_br;
      br_inv_d    = w_dec_inv;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_d   = w_dec_ill;
`else
      illegal_d   = 1'b0;
`endif
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= 4'd0;
      ina_q       <= '0;
      inb_q       <= '0;
      is_branch_q <= 1'b0;
      br_inv_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      ina_q       <= ina_d;
      inb_q       <= inb_d;
      is_branch_q <= is_branch_d;
      br_inv_q    <= br_inv_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.ina       = ina_q;
  assign bus.inb       = inb_q;
  assign bus.is_branch = is_branch_q;
  assign bus.br_inv    = br_inv_q;
  assign bus.illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_issue_stage                                            |
// | Purpose  : Directed self-checking bench for alu_issue_stage.             |
// | Options  : honours ALU_ISSUE_ILLEGAL_EN for the illegal-encoding checks. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alu_issue_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  alu_issue_stage_if #(.DATA_W(32)) bus ();

  alu_issue_stage #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fails++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [31:0] p);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.rs1_val  = r1;
    bus.rs2_val  = r2;
    bus.imm      = im;
    bus.pc       = p;
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.opcode    = 7'h00;
    bus.funct3    = 3'd0;
    bus.funct7    = 7'd0;
    bus.rs1_val   = '0;
    bus.rs2_val   = '0;
    bus.imm       = '0;
    bus.pc        = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu_op",    32'(bus.alu_op),    32'd0);
    chk("rst_ina",       bus.ina,            32'd0);
    chk("rst_inb",       bus.inb,            32'd0);
    chk("rst_is_branch", 32'(bus.is_branch), 32'd0);
    chk("rst_br_inv",    32'(bus.br_inv),    32'd0);
    chk("rst_illegal",   32'(bus.illegal),   32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    rst_n = 1'b1;
    step();

    // R-type SUB 10 - 3
    drive(7'h33, 3'b000, 7'h20, 32'd10, 32'd3, 32'd0, 32'd0);
    step();
    bus.in_valid = 1'b0;
    chk("sub_valid", 32'(bus.out_valid), 32'd1);
    chk("sub_op",    32'(bus.alu_op),    32'd6);
    chk("sub_ina",   bus.ina,            32'd10);
    chk("sub_inb",   bus.inb,            32'd3);
    chk("sub_br",    32'(bus.is_branch), 32'd0);
    step();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    // SRAI then SRLI back to back
    drive(7'h13, 3'b101, 7'h20, 32'h8000_0000, 32'd0, 32'd4, 32'd0);
    step();
    chk("srai_op",  32'(bus.alu_op), 32'd9);
    chk("srai_ina", bus.ina,         32'h8000_0000);
    chk("srai_inb", bus.inb,         32'd4);
    drive(7'h13, 3'b101, 7'h00, 32'h8000_0000, 32'd0, 32'd4, 32'd0);
    step();
    chk("srli_valid", 32'(bus.out_valid), 32'd1);
    chk("srli_op",    32'(bus.alu_op),    32'd5);

    // ADDI with funct7[5] set must stay ADD
    drive(7'h13, 3'b000, 7'h20, 32'd1, 32'd9, 32'd2, 32'd0);
    step();
    chk("addi_op",  32'(bus.alu_op), 32'd2);
    chk("addi_inb", bus.inb,         32'd2);

    // Branches
    drive(7'h63, 3'b111, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0);
    step();
    chk("bgeu_op",  32'(bus.alu_op),    32'd7);
    chk("bgeu_br",  32'(bus.is_branch), 32'd1);
    chk("bgeu_inv", 32'(bus.br_inv),    32'd1);
    chk("bgeu_inb", bus.inb,            32'd7);
    drive(7'h63, 3'b001, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0);
    step();
    chk("bne_op",  32'(bus.alu_op), 32'd6);
    chk("bne_inv", 32'(bus.br_inv), 32'd1);
    drive(7'h63, 3'b100, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0);
    step();
    chk("blt_op",  32'(bus.alu_op), 32'd8);
    chk("blt_inv", 32'(bus.br_inv), 32'd0);

    // AUIPC and LUI
    drive(7'h17, 3'b000, 7'h00, 32'd77, 32'd0, 32'h2000, 32'h100);
    step();
    chk("auipc_op",  32'(bus.alu_op),    32'd2);
    chk("auipc_ina", bus.ina,            32'h100);
    chk("auipc_inb", bus.inb,            32'h2000);
    chk("auipc_br",  32'(bus.is_branch), 32'd0);
    drive(7'h37, 3'b000, 7'h00, 32'd77, 32'd0, 32'h1234_5000, 32'h100);
    step();
    chk("lui_ina", bus.ina, 32'd0);
    chk("lui_inb", bus.inb, 32'h1234_5000);

    // Stall: LUI held, XOR waiting upstream
    bus.out_ready = 1'b0;
    drive(7'h33, 3'b100, 7'h00, 32'hA, 32'hB, 32'd0, 32'd0);
    #1;
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_op",    32'(bus.alu_op),    32'd2);
      chk("stall_inb",   bus.inb,            32'h1234_5000);
      chk("stall_rdy",   32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("release_op",    32'(bus.alu_op),    32'd3);
    chk("release_ina",   bus.ina,            32'hA);
    chk("release_valid", 32'(bus.out_valid), 32'd1);
    step();
    chk("release_once", 32'(bus.out_valid), 32'd0);

    // Flush with a held entry and a same-cycle accept
    drive(7'h33, 3'b110, 7'h00, 32'd1, 32'd2, 32'd0, 32'd0);
    step();
    chk("or_op", 32'(bus.alu_op), 32'd1);
    drive(7'h33, 3'b111, 7'h00, 32'd1, 32'd2, 32'd0, 32'd0);
    bus.flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    step();
    chk("flush_no_late", 32'(bus.out_valid), 32'd0);

    // Illegal opcode and illegal branch funct3
    drive(7'h7F, 3'b000, 7'h00, 32'h55, 32'd0, 32'h66, 32'd0);
    step();
`ifdef ALU_ISSUE_ILLEGAL_EN
    chk("ill_op",  32'(bus.alu_op),  32'd15);
    chk("ill_flg", 32'(bus.illegal), 32'd1);
    chk("ill_ina", bus.ina,          32'd0);
    chk("ill_inb", bus.inb,          32'd0);
`else
    chk("ill_op",  32'(bus.alu_op),  32'd2);
    chk("ill_flg", 32'(bus.illegal), 32'd0);
    chk("ill_ina", bus.ina,          32'h55);
    chk("ill_inb", bus.inb,          32'h66);
`endif
    chk("ill_valid", 32'(bus.out_valid), 32'd1);
    drive(7'h63, 3'b010, 7'h00, 32'h11, 32'h22, 32'h33, 32'd0);
    step();
    chk("illbr_br", 32'(bus.is_branch), 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    chk("illbr_op",  32'(bus.alu_op),  32'd15);
    chk("illbr_flg", 32'(bus.illegal), 32'd1);
`else
    chk("illbr_op",  32'(bus.alu_op),  32'd2);
    chk("illbr_inb", bus.inb,          32'h33);
`endif
    // Legal instruction clears the flag again
    drive(7'h03, 3'b010, 7'h00, 32'h40, 32'd0, 32'h8, 32'd0);
    step();
    chk("load_op",  32'(bus.alu_op),  32'd2);
    chk("load_ill", 32'(bus.illegal), 32'd0);
    chk("load_inb", bus.inb,          32'h8);

    // Asynchronous reset mid-stream
    drive(7'h63, 3'b101, 7'h00, 32'd9, 32'd8, 32'd0, 32'd0);
    step();
    chk("pre_rst_br", 32'(bus.is_branch), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_op",    32'(bus.alu_op),    32'd0);
    chk("arst_ina",   bus.ina,            32'd0);
    chk("arst_inb",   bus.inb,            32'd0);
    chk("arst_br",    32'(bus.is_branch), 32'd0);
    chk("arst_inv",   32'(bus.br_inv),    32'd0);
    chk("arst_ill",   32'(bus.illegal),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(7'h33, 3'b011, 7'h00, 32'd3, 32'd4, 32'd0, 32'd0);
    step();
    bus.in_valid = 1'b0;
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_op",    32'(bus.alu_op),    32'd7);
    chk("post_rst_inb",   bus.inb,            32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
